// File: rtl/bsg_chip_pkg.sv
// bsg_chip_pkg: chip-wide widths plus wormhole header view and link arbiter state
package bsg_chip_pkg;
  localparam int ct_width_gp = 32;
  localparam int wh_cord_width_gp = 5;
  localparam int wh_len_width_gp = 3;
  typedef struct packed {
    logic [wh_len_width_gp-1:0] len;
    logic [wh_cord_width_gp-1:0] cord;
  } bsg_chip_wh_hdr_s;
  typedef enum logic [1:0] {IDLE, HOLD, BUSY} bsg_chip_wh_arb_state_e;
endpackage

// File: rtl/bsg_chip_wh_rr_pick.sv
// bsg_chip_wh_rr_pick: rotating-priority encoder, first valid at or after ptr_i with wrap
module bsg_chip_wh_rr_pick #(
  parameter int num_in_p = 2,
  localparam int pw = $clog2(num_in_p)
) (
  input  logic [num_in_p-1:0] v_i,
  input  logic [pw-1:0]       ptr_i,
  output logic [num_in_p-1:0] grant_o,
  output logic [pw-1:0]       idx_o
);
  logic [pw-1:0] j;
  logic found;
  always_comb begin
    grant_o = '0;
    idx_o = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < num_in_p; k++) begin
      j = pw'((int'(ptr_i) + k) % num_in_p);
      if (!found && v_i[j]) begin
        found = 1'b1;
        grant_o[j] = 1'b1;
        idx_o = j;
      end
    end
  end
endmodule

// File: rtl/bsg_chip_wh_link_arbiter.sv
// bsg_chip_wh_link_arbiter: per-packet round-robin steering of wormhole links onto one router link
module bsg_chip_wh_link_arbiter
  import bsg_chip_pkg::*;
#(
  parameter int num_in_p = 2,
  parameter int width_p = ct_width_gp,
  parameter int cord_width_p = wh_cord_width_gp,
  parameter int len_width_p = wh_len_width_gp
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_in_p-1:0]               v_i,
  input  logic [num_in_p-1:0][width_p-1:0]  data_i,
  output logic [num_in_p-1:0]               ready_and_o,
  output logic                              v_o,
  output logic [width_p-1:0]                data_o,
  input  logic                              ready_and_i,
  output logic                              busy_o
);
  localparam int pw = $clog2(num_in_p);
  bsg_chip_wh_arb_state_e state_r;
  logic [pw-1:0] ptr_r, sel_r, g_idx, src, nxt;
  logic [num_in_p-1:0] g_oh;
  logic [len_width_p-1:0] cnt_r, len;
  logic acc;
  bsg_chip_wh_rr_pick #(.num_in_p(num_in_p)) pick (
    .v_i(v_i),
    .ptr_i(ptr_r),
    .grant_o(g_oh),
    .idx_o(g_idx)
  );
  // once an offer is made (HOLD) or a packet is mid-flight (BUSY) only sel_r may drive the link
  assign src = state_r == IDLE ? g_idx : sel_r;
  assign v_o = ~reset_i & v_i[src];
  assign data_o = data_i[src];
  assign acc = v_o & ready_and_i;
  assign ready_and_o = acc ? (state_r == IDLE ? g_oh : num_in_p'(1) << sel_r) : '0;
  assign len = data_o[cord_width_p +: len_width_p];
  assign nxt = src == pw'(num_in_p - 1) ? '0 : src + 1'b1;
  assign busy_o = state_r != IDLE;
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= IDLE;
      ptr_r <= '0;
      sel_r <= '0;
      cnt_r <= '0;
    end else begin
      case (state_r)
        IDLE, HOLD: if (v_o) begin
          sel_r <= src;
          if (acc && len == '0) begin
            state_r <= IDLE;
            ptr_r <= nxt;
          end else if (acc) begin
            state_r <= BUSY;
            cnt_r <= len;
          end else state_r <= HOLD;
        end
        BUSY: if (acc) begin
          cnt_r <= cnt_r - 1'b1;
          if (cnt_r == len_width_p'(1)) begin
            state_r <= IDLE;
            ptr_r <= nxt;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bsg_chip_wh_link_arbiter.sv
// tb_bsg_chip_wh_link_arbiter: directed scenarios plus randomized traffic against a packet-level model
module tb_bsg_chip_wh_link_arbiter;
  import bsg_chip_pkg::*;
  localparam int n = 3;
  localparam int w = ct_width_gp;
  logic clk = 1'b0;
  logic reset_i;
  logic [n-1:0] v_i, ready_and_o;
  logic [n-1:0][w-1:0] data_i;
  logic v_o, ready_and_i, busy_o;
  logic [w-1:0] data_o;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bsg_chip_wh_link_arbiter #(.num_in_p(n)) dut (
    .clk_i(clk),
    .reset_i(reset_i),
    .v_i(v_i),
    .data_i(data_i),
    .ready_and_o(ready_and_o),
    .v_o(v_o),
    .data_o(data_o),
    .ready_and_i(ready_and_i),
    .busy_o(busy_o)
  );

  function automatic logic [w-1:0] hdr(int src, int len, int tag);
    bsg_chip_wh_hdr_s h;
    h.len = wh_len_width_gp'(len);
    h.cord = wh_cord_width_gp'(src + 1);
    return {4'(src), 20'(tag), h};
  endfunction

  function automatic logic [w-1:0] body(int src, int k);
    return {4'(src), 4'hb, 24'(k)};
  endfunction

  task automatic do_reset;
    reset_i = 1'b1;
    v_i = '0;
    ready_and_i = 1'b0;
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    v_i = '1;
    ready_and_i = 1'b1;
    for (int i = 0; i < n; i++) data_i[i] = hdr(i, 2, 0);
    #1;
    checks++;
    if ({v_o, ready_and_o} !== 4'b0) begin
      errors++;
      $display("FAIL reset_forced got v=%b r=%b exp v=0 r=000", v_o, ready_and_o);
    end
    @(negedge clk);
    v_i = '0;
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_idle got v=%b r=%b busy=%b exp 0 000 0", v_o, ready_and_o, busy_o);
    end
    reset_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_packet;
    logic [w-1:0] f;
    do_reset;
    ready_and_i = 1'b1;
    v_i = 3'b001;
    for (int k = 0; k < 4; k++) begin
      f = k == 0 ? hdr(0, 3, 1) : body(0, k);
      data_i[0] = f;
      #1;
      checks++;
      if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, k != 0, f}) begin
        errors++;
        $display("FAIL single[%0d] got v=%b r=%b busy=%b d=%h exp v=1 r=001 busy=%b d=%h",
                 k, v_o, ready_and_o, busy_o, data_o, k != 0, f);
      end
      @(negedge clk);
    end
    v_i = '0;
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o} !== 5'b0) begin
      errors++;
      $display("FAIL single_done got v=%b r=%b busy=%b exp 0 000 0", v_o, ready_and_o, busy_o);
    end
    ready_and_i = 1'b0;
    data_i[0] = hdr(0, 0, 2);
    data_i[1] = hdr(1, 0, 2);
    v_i = 3'b011;
    #1;
    checks++;
    if ({v_o, ready_and_o, data_o} !== {1'b1, 3'b000, hdr(1, 0, 2)}) begin
      errors++;
      $display("FAIL single_ptr got v=%b r=%b d=%h exp v=1 r=000 d=%h", v_o, ready_and_o, data_o, hdr(1, 0, 2));
    end
    @(negedge clk);
  endtask

  task automatic test_alternate;
    int pos[2];
    int s, p;
    logic [w-1:0] e;
    do_reset;
    pos = '{0, 0};
    ready_and_i = 1'b1;
    v_i = 3'b011;
    for (int c = 0; c < 8; c++) begin
      for (int i = 0; i < 2; i++) data_i[i] = pos[i] % 2 == 0 ? hdr(i, 1, pos[i] / 2) : body(i, pos[i]);
      #1;
      s = (c / 2) % 2;
      p = c / 4;
      e = c % 2 == 0 ? hdr(s, 1, p) : body(s, 2 * p + 1);
      checks++;
      if ({v_o, data_o} !== {1'b1, e}) begin
        errors++;
        $display("FAIL alternate[%0d] got v=%b d=%h exp v=1 d=%h", c, v_o, data_o, e);
      end
      for (int i = 0; i < 2; i++) if (ready_and_o[i]) pos[i]++;
      @(negedge clk);
    end
  endtask

  task automatic test_hold;
    do_reset;
    ready_and_i = 1'b1;
    v_i = 3'b001;
    data_i[0] = hdr(0, 0, 9);
    @(negedge clk);
    ready_and_i = 1'b0;
    data_i[0] = hdr(0, 1, 3);
    data_i[1] = hdr(1, 0, 3);
    for (int c = 0; c < 5; c++) begin
      v_i = c >= 2 ? 3'b011 : 3'b001;
      #1;
      checks++;
      if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b000, c != 0, hdr(0, 1, 3)}) begin
        errors++;
        $display("FAIL hold[%0d] got v=%b r=%b busy=%b d=%h exp v=1 r=000 busy=%b d=%h",
                 c, v_o, ready_and_o, busy_o, data_o, c != 0, hdr(0, 1, 3));
      end
      @(negedge clk);
    end
    ready_and_i = 1'b1;
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, 1'b1, hdr(0, 1, 3)}) begin
      errors++;
      $display("FAIL hold_accept got v=%b r=%b busy=%b d=%h", v_o, ready_and_o, busy_o, data_o);
    end
    @(negedge clk);
    data_i[0] = body(0, 1);
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, 1'b1, body(0, 1)}) begin
      errors++;
      $display("FAIL hold_body got v=%b r=%b busy=%b d=%h exp d=%h", v_o, ready_and_o, busy_o, data_o, body(0, 1));
    end
    @(negedge clk);
    v_i = 3'b010;
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b010, 1'b0, hdr(1, 0, 3)}) begin
      errors++;
      $display("FAIL hold_next got v=%b r=%b busy=%b d=%h exp d=%h", v_o, ready_and_o, busy_o, data_o, hdr(1, 0, 3));
    end
    @(negedge clk);
  endtask

  task automatic test_bubble;
    do_reset;
    ready_and_i = 1'b1;
    v_i = 3'b001;
    for (int i = 0; i < n; i++) data_i[i] = hdr(i, i == 0 ? 3 : 0, 4);
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, 1'b0, hdr(0, 3, 4)}) begin
      errors++;
      $display("FAIL bubble_hdr got v=%b r=%b busy=%b d=%h", v_o, ready_and_o, busy_o, data_o);
    end
    @(negedge clk);
    data_i[0] = body(0, 1);
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, 1'b1, body(0, 1)}) begin
      errors++;
      $display("FAIL bubble_body1 got v=%b r=%b busy=%b d=%h", v_o, ready_and_o, busy_o, data_o);
    end
    @(negedge clk);
    for (int c = 0; c < 3; c++) begin
      v_i = 3'b110;
      #1;
      checks++;
      if ({v_o, ready_and_o, busy_o} !== {1'b0, 3'b000, 1'b1}) begin
        errors++;
        $display("FAIL bubble_gap[%0d] got v=%b r=%b busy=%b exp 0 000 1", c, v_o, ready_and_o, busy_o);
      end
      @(negedge clk);
    end
    for (int k = 2; k < 4; k++) begin
      v_i = 3'b111;
      data_i[0] = body(0, k);
      #1;
      checks++;
      if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, 1'b1, body(0, k)}) begin
        errors++;
        $display("FAIL bubble_resume[%0d] got v=%b r=%b busy=%b d=%h", k, v_o, ready_and_o, busy_o, data_o);
      end
      @(negedge clk);
    end
    v_i = 3'b110;
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b010, 1'b0, hdr(1, 0, 4)}) begin
      errors++;
      $display("FAIL bubble_next got v=%b r=%b busy=%b d=%h", v_o, ready_and_o, busy_o, data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_wrap;
    do_reset;
    ready_and_i = 1'b1;
    for (int i = 0; i < n; i++) data_i[i] = hdr(i, 0, 5);
    v_i = 3'b100;
    #1;
    checks++;
    if ({v_o, ready_and_o, data_o} !== {1'b1, 3'b100, hdr(2, 0, 5)}) begin
      errors++;
      $display("FAIL wrap_grant2 got v=%b r=%b d=%h", v_o, ready_and_o, data_o);
    end
    @(negedge clk);
    v_i = 3'b101;
    #1;
    checks++;
    if ({v_o, ready_and_o, data_o} !== {1'b1, 3'b001, hdr(0, 0, 5)}) begin
      errors++;
      $display("FAIL wrap_grant0 got v=%b r=%b d=%h exp r=001", v_o, ready_and_o, data_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if ({v_o, ready_and_o, data_o} !== {1'b1, 3'b100, hdr(2, 0, 5)}) begin
      errors++;
      $display("FAIL wrap_rotate got v=%b r=%b d=%h exp r=100", v_o, ready_and_o, data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_packet;
    do_reset;
    ready_and_i = 1'b1;
    v_i = 3'b001;
    data_i[0] = hdr(0, 0, 6);
    @(negedge clk);
    v_i = 3'b010;
    data_i[1] = hdr(1, 5, 6);
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b010, 1'b0, hdr(1, 5, 6)}) begin
      errors++;
      $display("FAIL rst_mid_hdr got v=%b r=%b busy=%b d=%h", v_o, ready_and_o, busy_o, data_o);
    end
    @(negedge clk);
    data_i[1] = body(1, 1);
    reset_i = 1'b1;
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o} !== {1'b0, 3'b000, 1'b1}) begin
      errors++;
      $display("FAIL rst_mid_forced got v=%b r=%b busy=%b exp 0 000 1", v_o, ready_and_o, busy_o);
    end
    @(negedge clk);
    reset_i = 1'b0;
    v_i = 3'b011;
    data_i[0] = hdr(0, 0, 7);
    data_i[1] = hdr(1, 0, 7);
    #1;
    checks++;
    if ({v_o, ready_and_o, busy_o, data_o} !== {1'b1, 3'b001, 1'b0, hdr(0, 0, 7)}) begin
      errors++;
      $display("FAIL rst_mid_after got v=%b r=%b busy=%b d=%h exp r=001 busy=0", v_o, ready_and_o, busy_o, data_o);
    end
    @(negedge clk);
    v_i = 3'b010;
    #1;
    checks++;
    if ({v_o, ready_and_o, data_o} !== {1'b1, 3'b010, hdr(1, 0, 7)}) begin
      errors++;
      $display("FAIL rst_mid_in1 got v=%b r=%b d=%h", v_o, ready_and_o, data_o);
    end
    @(negedge clk);
  endtask

  task automatic test_random;
    int len[n], pos[n], tag[n];
    bit off[n];
    int owner, left, ptr, cand, s, j;
    logic ev;
    logic [n-1:0] er;
    logic [w-1:0] ed;
    do_reset;
    for (int i = 0; i < n; i++) begin
      len[i] = $urandom_range(0, 5);
      pos[i] = 0;
      tag[i] = 0;
      off[i] = 1'b0;
    end
    owner = -1;
    left = -1;
    ptr = 0;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < n; i++) begin
        if (!off[i]) off[i] = $urandom_range(0, 2) != 0;
        v_i[i] = off[i];
        data_i[i] = pos[i] == 0 ? hdr(i, len[i], tag[i]) : body(i, tag[i] * 16 + pos[i]);
      end
      ready_and_i = $urandom_range(0, 3) != 0;
      #1;
      cand = -1;
      for (int k = 0; k < n; k++) begin
        j = (ptr + k) % n;
        if (cand < 0 && off[j]) cand = j;
      end
      s = owner >= 0 ? owner : cand;
      ev = s >= 0 ? off[s] : 1'b0;
      er = (ev && ready_and_i) ? n'(1) << s : '0;
      ed = ev ? data_i[s] : '0;
      checks++;
      if ({v_o, ready_and_o, busy_o} !== {ev, er, owner >= 0} || (ev && data_o !== ed)) begin
        errors++;
        $display("FAIL random[%0d] got v=%b r=%b busy=%b d=%h exp v=%b r=%b busy=%b d=%h",
                 c, v_o, ready_and_o, busy_o, data_o, ev, er, owner >= 0, ed);
      end
      if (ev) begin
        if (owner < 0) begin
          owner = s;
          left = -1;
        end
        if (ready_and_i) begin
          left = left < 0 ? len[s] : left - 1;
          pos[s]++;
          off[s] = 1'b0;
          if (pos[s] > len[s]) begin
            pos[s] = 0;
            tag[s]++;
            len[s] = $urandom_range(0, 5);
          end
          if (left == 0) begin
            owner = -1;
            ptr = (s + 1) % n;
          end
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset_i = 1'b1;
    v_i = '0;
    ready_and_i = 1'b0;
    data_i = '0;
    @(negedge clk);
    test_reset;
    test_single_packet;
    test_alternate;
    test_hold;
    test_bubble;
    test_wrap;
    test_reset_mid_packet;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
